adder_arbiter: RTL
==================

Name: adder_arbiter

Overview:
Shares one external adder32 instance between two requesters. Arbitration is round-robin.
- Accepts an operand pair (a, b, cin) from the winning requester over a valid/ready handshake.
- Drives that pair onto the adder inputs and registers result/cout.
- Returns the result to the winner over a valid/ready response handshake.
- Sits between the ALU-side clients and the adder32 datapath; one transaction in flight at a time.

Parameters:
WIDTH, 32, operand/result width; must match the attached adder32.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has an operand pair
req0_ready  output  1  requester 0 pair accepted this cycle
req0_a  input  WIDTH  requester 0 operand1
req0_b  input  WIDTH  requester 0 operand2
req0_cin  input  1  requester 0 carry-in
resp0_valid  output  1  requester 0 result available
resp0_ready  input  1  requester 0 takes result
resp0_sum  output  WIDTH  result for requester 0
resp0_cout  output  1  carry-out for requester 0
resp0_ovf  output  1  signed overflow for requester 0
req1_*, resp1_*  same set as requester 0, for requester 1
add_operand1  output  WIDTH  to adder32 operand1
add_operand2  output  WIDTH  to adder32 operand2
add_cin  output  1  to adder32 cin
add_result  input  WIDTH  from adder32 result
add_cout  input  1  from adder32 cout
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset state:
  - FSM = IDLE; priority pointer = 0 (requester 0 favoured).
  - All outputs 0: req*_ready, resp*_valid, resp*_sum/cout/ovf, add_operand1/2, add_cin, busy.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection:
    - Only one req*_valid high: that requester wins.
    - Both high: the requester named by the pointer wins.
  - Winner's req*_ready is asserted combinationally in the same cycle; the loser's ready stays 0.
  - Ready is never asserted outside IDLE.
  - On the accept edge:
    - a, b, cin are latched into operand registers that drive add_operand1/2 and add_cin.
    - The granted id is stored.
    - Next state is EXEC.
- EXEC (exactly 1 cycle):
  - Adder output settles from the registered operands.
  - At the end of the cycle, add_result and add_cout are captured into the granted requester's resp registers.
  - ovf is computed as (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
  - Next state is RESP.
- RESP:
  - Only the granted requester's resp*_valid is high; sum/cout/ovf are held stable.
  - When resp*_ready is sampled high:
    - valid deasserts on the next edge and the state returns to IDLE.
    - The pointer is set to the other requester (the one not just served).
- Latency and throughput:
  - Accept at edge T, resp_valid visible from T+2.
  - Minimum 3 cycles per transaction: IDLE, EXEC, RESP.
- Operand registers hold their last values after a transaction; the adder inputs do not return to 0.
- Backpressure: while in RESP with resp_ready low, the FSM stays put indefinitely; no new request is accepted.
- Simultaneous events:
  - A request asserted during EXEC/RESP waits; valid must stay high until ready.
  - The requester being served may assert a new req_valid during RESP; it is considered in the next IDLE under the updated pointer.
- Reset mid-operation (EXEC or RESP):
  - The transaction is dropped; no response is issued.
  - All outputs return to reset values on the reset edge.
- Width rules: sum is WIDTH bits, modulo 2^WIDTH; cout is taken directly from the adder.

Test Plan:
1. Single request on requester 0:
   - Stimulus: req0 a=0x00000005, b=0x00000003, cin=1, accepted at edge T.
   - Required: resp0_valid at T+2 with sum=0x00000009, cout=0, ovf=0; resp1_valid stays 0.
2. Contention after reset:
   - Stimulus: req0 and req1 valid together.
   - Required: req0 granted first; req1 granted in the next IDLE.
   - Then: with both kept valid, grants alternate 0,1,0,1 over 4 transactions.
3. Carry and overflow:
   - a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, ovf=0.
   - a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1.
4. Response backpressure:
   - Stimulus: resp1_ready held low for 5 cycles in RESP while req0_valid is high.
   - Required: resp1 data stable, busy=1, req0_ready=0 throughout.
   - Then: req0 is accepted in the IDLE cycle right after the resp1 handshake.
5. Reset mid-transaction:
   - Stimulus: rst high for one cycle during EXEC.
   - Required: no resp*_valid, all outputs 0.
   - Then: a following simultaneous request grants req0 first.
6. Random soak:
   - Stimulus: 1000 transactions with random operands on both requesters.
   - Required: every response equals {cout,sum} = a+b+cin; none lost or duplicated.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external adder32 between two requesters.
// One transaction is in flight at a time: accept in IDLE, add in EXEC, hand back in RESP.
module adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_sum,
    output logic             resp0_cout,
    output logic             resp0_ovf,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_sum,
    output logic             resp1_cout,
    output logic             resp1_ovf,

    output logic [WIDTH-1:0] add_operand1,
    output logic [WIDTH-1:0] add_operand2,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_cout,

    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic             cin_q, cin_d;

    logic             valid0_q, valid0_d;
    logic [WIDTH-1:0] sum0_q, sum0_d;
    logic             cout0_q, cout0_d;
    logic             ovf0_q, ovf0_d;

    logic             valid1_q, valid1_d;
    logic [WIDTH-1:0] sum1_q, sum1_d;
    logic             cout1_q, cout1_d;
    logic             ovf1_q, ovf1_d;

    logic             anyReq;
    logic             winId;
    logic             accept;
    logic             respTaken;
    logic             addOvf;

    // With both requesters pending the pointer decides; otherwise the lone requester wins.
    always_comb begin
        anyReq    = req0_valid | req1_valid;
        winId     = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        accept    = (state_q == IDLE) && anyReq;
        respTaken = grant_q ? resp1_ready : resp0_ready;
        addOvf    = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) &&
                    (add_result[WIDTH-1] != op1_q[WIDTH-1]);
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        cin_d    = cin_q;
        valid0_d = valid0_q;
        sum0_d   = sum0_q;
        cout0_d  = cout0_q;
        ovf0_d   = ovf0_q;
        valid1_d = valid1_q;
        sum1_d   = sum1_q;
        cout1_d  = cout1_q;
        ovf1_d   = ovf1_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d = winId;
                    op1_d   = winId ? req1_a   : req0_a;
                    op2_d   = winId ? req1_b   : req0_b;
                    cin_d   = winId ? req1_cin : req0_cin;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (grant_q) begin
                    valid1_d = 1'b1;
                    sum1_d   = add_result;
                    cout1_d  = add_cout;
                    ovf1_d   = addOvf;
                end else begin
                    valid0_d = 1'b1;
                    sum0_d   = add_result;
                    cout0_d  = add_cout;
                    ovf0_d   = addOvf;
                end
                state_d = RESP;
            end
            RESP: begin
                // Result data stays put after the handshake; only valid drops.
                if (respTaken) begin
                    valid0_d = 1'b0;
                    valid1_d = 1'b0;
                    ptr_d    = ~grant_q;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            grant_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            cin_q    <= 1'b0;
            valid0_q <= 1'b0;
            sum0_q   <= '0;
            cout0_q  <= 1'b0;
            ovf0_q   <= 1'b0;
            valid1_q <= 1'b0;
            sum1_q   <= '0;
            cout1_q  <= 1'b0;
            ovf1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            cin_q    <= cin_d;
            valid0_q <= valid0_d;
            sum0_q   <= sum0_d;
            cout0_q  <= cout0_d;
            ovf0_q   <= ovf0_d;
            valid1_q <= valid1_d;
            sum1_q   <= sum1_d;
            cout1_q  <= cout1_d;
            ovf1_q   <= ovf1_d;
        end
    end

    assign req0_ready   = accept && !winId;
    assign req1_ready   = accept && winId;

    assign resp0_valid  = valid0_q;
    assign resp0_sum    = sum0_q;
    assign resp0_cout   = cout0_q;
    assign resp0_ovf    = ovf0_q;
    assign resp1_valid  = valid1_q;
    assign resp1_sum    = sum1_q;
    assign resp1_cout   = cout1_q;
    assign resp1_ovf    = ovf1_q;

    assign add_operand1 = op1_q;
    assign add_operand2 = op2_q;
    assign add_cin      = cin_q;

    assign busy         = (state_q != IDLE);

endmodule
